// File: rtl/rst_seq_pkg.sv
// Shared types and defaults for the staged reset sequencer.
// Holds the state encoding and a helper for sizing the shared down-counter.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_QUIESCE = 2'd3
  } state_e;

  localparam int DEF_NUM_DOMAINS     = 4;
  localparam int DEF_HOLD_CYCLES     = 16;
  localparam int DEF_STAGE_GAP       = 4;
  localparam int DEF_QUIESCE_TIMEOUT = 64;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rst_seq_sync.sv
// Two-flop reset synchronizer: asserts asynchronously with rst_n and
// releases on the second clock edge after rst_n rises.
module rst_sync_cell (
  input  logic clk,
  input  logic rst_n,
  output logic srst_n
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= 1'b1;
      sync_reg <= meta_reg;
    end
  end

  assign srst_n = sync_reg;

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: holds all domains in reset, releases them one by one,
// and runs a quiesce handshake before any software-requested reset.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOMAINS     = DEF_NUM_DOMAINS,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int STAGE_GAP       = DEF_STAGE_GAP,
  parameter int QUIESCE_TIMEOUT = DEF_QUIESCE_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sw_rst_req,
  output logic                   sw_rst_ack,
  output logic                   quiesce_req,
  input  logic                   quiesce_ack,
  output logic [NUM_DOMAINS-1:0] rst_out_n,
  output logic                   rst_done,
  output logic                   timeout_flag
);

  localparam int CNT_W = $clog2(max3(HOLD_CYCLES, STAGE_GAP, QUIESCE_TIMEOUT) + 1);
  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  // Loads are one less than the interval because the zero cycle itself counts.
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] QT_LOAD   = CNT_W'(QUIESCE_TIMEOUT - 1);

  logic srst_n;

  rst_sync_cell u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .srst_n (srst_n)
  );

  state_e                 state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [IDX_W-1:0]       idx_reg, idx_next;
  logic [NUM_DOMAINS-1:0] out_reg, out_next;
  logic                   done_reg, done_next;
  logic                   ack_reg, ack_next;
  logic                   qreq_reg, qreq_next;
  logic                   tflag_reg, tflag_next;
  logic                   sw_seq_reg, sw_seq_next;

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state_reg  <= ST_HOLD;
      cnt_reg    <= HOLD_LOAD;
      idx_reg    <= '0;
      out_reg    <= '0;
      done_reg   <= 1'b0;
      ack_reg    <= 1'b0;
      qreq_reg   <= 1'b0;
      tflag_reg  <= 1'b0;
      sw_seq_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      idx_reg    <= idx_next;
      out_reg    <= out_next;
      done_reg   <= done_next;
      ack_reg    <= ack_next;
      qreq_reg   <= qreq_next;
      tflag_reg  <= tflag_next;
      sw_seq_reg <= sw_seq_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    idx_next    = idx_reg;
    out_next    = out_reg;
    done_next   = done_reg;
    ack_next    = ack_reg;
    qreq_next   = qreq_reg;
    tflag_next  = tflag_reg;
    sw_seq_next = sw_seq_reg;

    if (ack_reg && !sw_rst_req) begin
      ack_next = 1'b0;
    end

    case (state_reg)
      ST_HOLD: begin
        if (cnt_reg == '0) begin
          state_next  = ST_RELEASE;
          out_next[0] = 1'b1;
          idx_next    = IDX_W'(1);
          cnt_next    = GAP_LOAD;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        // rst_done trails the last release by one cycle.
        if (&out_reg) begin
          state_next = ST_RUN;
          done_next  = 1'b1;
          if (sw_seq_reg) begin
            ack_next    = 1'b1;
            sw_seq_next = 1'b0;
          end
        end else if (cnt_reg == '0) begin
          out_next[idx_reg] = 1'b1;
          idx_next          = idx_reg + IDX_W'(1);
          cnt_next          = GAP_LOAD;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (sw_rst_req && !ack_reg) begin
          state_next  = ST_QUIESCE;
          qreq_next   = 1'b1;
          cnt_next    = QT_LOAD;
          tflag_next  = 1'b0;
          sw_seq_next = 1'b1;
        end
      end
      ST_QUIESCE: begin
        // An ack arriving on the timeout cycle still counts as a clean drain.
        if (quiesce_ack || cnt_reg == '0) begin
          state_next = ST_HOLD;
          qreq_next  = 1'b0;
          out_next   = '0;
          done_next  = 1'b0;
          idx_next   = '0;
          cnt_next   = HOLD_LOAD;
          if (!quiesce_ack) begin
            tflag_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_HOLD;
      end
    endcase
  end

  assign rst_out_n    = out_reg;
  assign rst_done     = done_reg;
  assign sw_rst_ack   = ack_reg;
  assign quiesce_req  = qreq_reg;
  assign timeout_flag = tflag_reg;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq: power-up staging, software reset with and
// without quiesce ack, held requests, and reset pulses mid-sequence.
module tb_rst_seq;

  localparam int N  = 4;
  localparam int H  = 16;
  localparam int G  = 4;
  localparam int QT = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sw_rst_req = 1'b0;
  logic         quiesce_ack = 1'b0;
  logic         sw_rst_ack, quiesce_req, rst_done, timeout_flag;
  logic [N-1:0] rst_out_n;
  logic         b_ack, b_qreq, b_done, b_tflag;
  logic [0:0]   b_out;

  always #5 clk = ~clk;

  rst_seq #(
    .NUM_DOMAINS(N), .HOLD_CYCLES(H), .STAGE_GAP(G), .QUIESCE_TIMEOUT(QT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw_rst_req   (sw_rst_req),
    .sw_rst_ack   (sw_rst_ack),
    .quiesce_req  (quiesce_req),
    .quiesce_ack  (quiesce_ack),
    .rst_out_n    (rst_out_n),
    .rst_done     (rst_done),
    .timeout_flag (timeout_flag)
  );

  rst_seq #(
    .NUM_DOMAINS(1), .HOLD_CYCLES(1), .STAGE_GAP(1), .QUIESCE_TIMEOUT(4)
  ) dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw_rst_req   (1'b0),
    .sw_rst_ack   (b_ack),
    .quiesce_req  (b_qreq),
    .quiesce_ack  (1'b0),
    .rst_out_n    (b_out),
    .rst_done     (b_done),
    .timeout_flag (b_tflag)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int org      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Cycle (relative to org) at which each event was last seen; -1 = never.
  int out_rise [N];
  int out_fall, done_rise, done_fall, ack_rise, ack_fall;
  int q_first, q_last, q_rises, tf_rise, tf_fall, b_out_rise, b_done_rise;
  logic [N-1:0] prev_out;
  logic prev_done, prev_ack, prev_q, prev_tf, prev_b_out, prev_b_done;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_rec();
    for (int i = 0; i < N; i++) out_rise[i] = -1;
    out_fall = -1; done_rise = -1; done_fall = -1; ack_rise = -1; ack_fall = -1;
    q_first = -1; q_last = -1; q_rises = 0; tf_rise = -1; tf_fall = -1;
    b_out_rise = -1; b_done_rise = -1;
    prev_out = rst_out_n; prev_done = rst_done; prev_ack = sw_rst_ack;
    prev_q = quiesce_req; prev_tf = timeout_flag;
    prev_b_out = b_out[0]; prev_b_done = b_done;
  endtask

  // Each iteration samples at a negedge: the values seen by the next posedge,
  // which is cycle k. quiesce_ack/sw_rst_req drives land on that same edge.
  task automatic watch(input int n, input int ack_at, input int drop_at);
    int k;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      k = cyc + 1 - org;
      for (int i = 0; i < N; i++)
        if (rst_out_n[i] && !prev_out[i]) out_rise[i] = k;
      if (rst_out_n == '0 && prev_out != '0) out_fall = k;
      if (rst_done && !prev_done) done_rise = k;
      if (!rst_done && prev_done) done_fall = k;
      if (sw_rst_ack && !prev_ack) ack_rise = k;
      if (!sw_rst_ack && prev_ack) ack_fall = k;
      if (timeout_flag && !prev_tf) tf_rise = k;
      if (!timeout_flag && prev_tf) tf_fall = k;
      if (quiesce_req) begin
        if (q_first < 0) q_first = k;
        q_last = k;
        if (!prev_q) q_rises++;
      end
      if (b_out[0] && !prev_b_out) b_out_rise = k;
      if (b_done && !prev_b_done) b_done_rise = k;
      prev_out = rst_out_n; prev_done = rst_done; prev_ack = sw_rst_ack;
      prev_q = quiesce_req; prev_tf = timeout_flag;
      prev_b_out = b_out[0]; prev_b_done = b_done;
      quiesce_ack = (k == ack_at);
      if (k == drop_at) sw_rst_req = 1'b0;
    end
  endtask

  // Called at a negedge: two sync edges follow, the third is cycle 0.
  task automatic power_up();
    rst_n = 1'b1;
    org = cyc + 3;
    clear_rec();
  endtask

  // Called at a negedge: the next posedge (cycle 0) samples the new request level.
  task automatic start_rel();
    org = cyc + 1;
    clear_rec();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_out_n_reset", rst_out_n, 0);
    check("rst_done_reset", rst_done, 0);
    check("ack_reset", sw_rst_ack, 0);
    check("qreq_reset", quiesce_req, 0);
    check("tflag_reset", timeout_flag, 0);

    power_up();
    watch(40, -1, -1);
    for (int i = 0; i < N; i++) check($sformatf("pwr_out%0d", i), out_rise[i], H + i * G);
    check("pwr_done", done_rise, 29);
    check("pwr_ack", ack_rise, -1);
    check("b_out0", b_out_rise, 1);
    check("b_done", b_done_rise, 2);
    check("b_qreq", b_qreq, 0);
    check("b_ack", b_ack, 0);
    $display("[tb] power-up: out0 %0d out3 %0d done %0d", out_rise[0], out_rise[N-1], done_rise);

    sw_rst_req = 1'b1;
    start_rel();
    watch(40, 5, -1);
    check("sw5_q_first", q_first, 1);
    check("sw5_q_last", q_last, 5);
    check("sw5_out_fall", out_fall, 6);
    check("sw5_done_fall", done_fall, 6);
    check("sw5_out0", out_rise[0], 22);
    check("sw5_out3", out_rise[3], 34);
    check("sw5_done", done_rise, 35);
    check("sw5_ack", ack_rise, 35);
    check("sw5_tflag", tf_rise, -1);
    sw_rst_req = 1'b0;
    start_rel();
    watch(4, -1, -1);
    check("sw5_ack_fall", ack_fall, 1);
    check("sw5_no_retrig", q_first, -1);
    $display("[tb] sw reset ack@5: out_fall %0d done %0d ack %0d", out_fall, done_rise, ack_rise);

    sw_rst_req = 1'b1;
    start_rel();
    watch(60, 3, 50);
    check("held_q_rises", q_rises, 1);
    check("held_out_fall", out_fall, 4);
    check("held_ack", ack_rise, 33);
    check("held_ack_fall", ack_fall, 51);
    $display("[tb] held request: q_rises %0d ack %0d..%0d", q_rises, ack_rise, ack_fall);

    sw_rst_req = 1'b1;
    start_rel();
    watch(100, -1, -1);
    check("to_q_last", q_last, QT);
    check("to_out_fall", out_fall, QT + 1);
    check("to_tflag_rise", tf_rise, QT + 1);
    check("to_done", done_rise, QT + 30);
    check("to_ack", ack_rise, QT + 30);
    sw_rst_req = 1'b0;
    start_rel();
    watch(4, -1, -1);
    check("to_ack_fall", ack_fall, 1);
    check("to_tflag_sticky", timeout_flag, 1);
    $display("[tb] quiesce timeout: forced reset %0d tflag %0d", out_fall, timeout_flag);

    sw_rst_req = 1'b1;
    start_rel();
    watch(100, QT, -1);
    check("tie_tflag_clear", tf_fall, 1);
    check("tie_tflag_rise", tf_rise, -1);
    check("tie_out_fall", out_fall, QT + 1);
    check("tie_ack", ack_rise, QT + 30);
    sw_rst_req = 1'b0;
    start_rel();
    watch(4, -1, -1);
    $display("[tb] ack on timeout cycle: tflag %0d", timeout_flag);

    rst_n = 1'b0;
    #1;
    check("async_out", rst_out_n, 0);
    check("async_done", rst_done, 0);
    repeat (2) @(negedge clk);
    power_up();
    watch(24, -1, -1);
    check("mid_out_pre", rst_out_n, 4'b0011);
    rst_n = 1'b0;
    #1;
    check("mid_out_async", rst_out_n, 0);
    repeat (2) @(negedge clk);
    power_up();
    watch(10, -1, -1);
    sw_rst_req = 1'b1;
    watch(21, -1, -1);
    check("re_out0", out_rise[0], 16);
    check("re_out3", out_rise[3], 28);
    check("re_done", done_rise, 29);
    watch(45, 33, -1);
    check("hold_req_q_first", q_first, 30);
    check("hold_req_out_fall", out_fall, 34);
    check("hold_req_ack", ack_rise, 63);
    sw_rst_req = 1'b0;
    start_rel();
    watch(3, -1, -1);
    check("hold_req_ack_fall", ack_fall, 1);
    $display("[tb] rst_n mid-release + HOLD request: q_first 30 ack_fall %0d", ack_fall);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rst_seq.md
# rst_seq

Reset sequencer that turns the board-level asynchronous reset and a software reset request into `NUM_DOMAINS` staged, synchronously-released reset outputs. It owns the initiating side of the design's reset interface: it decides when each downstream block enters and leaves reset. Each downstream block consumes one `rst_out_n` bit as its asynchronous reset. Before a software reset, it quiesces downstream traffic with a request/acknowledge handshake.

## Interface
- `NUM_DOMAINS`, default 4: number of reset outputs, released in index order; must be ≥1.
- `HOLD_CYCLES`, default 16: cycles all outputs stay asserted before the first release; must be ≥1.
- `STAGE_GAP`, default 4: cycles between consecutive releases; must be ≥1.
- `QUIESCE_TIMEOUT`, default 64: maximum cycles to wait for `quiesce_ack`; must be ≥1.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `sw_rst_req` in 1: software reset request; level, four-phase handshake.
- `sw_rst_ack` out 1: software reset complete; level.
- `quiesce_req` out 1: asks downstream to drain and stop.
- `quiesce_ack` in 1: downstream is idle; synchronous to `clk`.
- `rst_out_n` out `NUM_DOMAINS`: per-domain reset, active-low.
- `rst_done` out 1: all domains are out of reset.
- `timeout_flag` out 1: the last quiesce phase ended by timeout.

## Operation
- **Input synchronizer:** `rst_n` passes through a 2-flop synchronizer (asynchronous assert, synchronous release) to produce the internal reset `srst_n`.
- **States:**
  - `HOLD`: all outputs asserted; counts `HOLD_CYCLES`.
  - `RELEASE`: deasserts `rst_out_n[i]` in index order, one every `STAGE_GAP` cycles.
  - `RUN`: `rst_done`=1.
  - `QUIESCE`: `quiesce_req`=1; waits for `quiesce_ack` or timeout.
- **Transitions:**
  - `srst_n`=0 → `HOLD` (asynchronous).
  - `HOLD` → `RELEASE` when the count expires.
  - `RELEASE` → `RUN` after the last release.
  - `RUN` → `QUIESCE` when `sw_rst_req`=1 and `sw_rst_ack`=0.
  - `QUIESCE` → `HOLD` on `quiesce_ack`=1 or timeout.
- **Software request acceptance:** only in `RUN` with `sw_rst_ack` low. Requests in other states stay pending and are not lost. They are evaluated on `RUN` entry.
- **Handshake:**
  - `sw_rst_ack` rises in the same cycle `rst_done` rises at the end of a software-initiated sequence.
  - It stays high while `sw_rst_req` is high.
  - It falls the cycle after `sw_rst_req` is sampled low.
  - A held request never retriggers.
- **Timeout:** if `quiesce_ack` is not seen within `QUIESCE_TIMEOUT` cycles, reset is forced and `timeout_flag` is set. `timeout_flag` is sticky and clears when the next request is accepted. A power-up sequence does not clear it; `rst_n` does.
- **Counter width:** one shared down-counter, `$clog2(max(HOLD_CYCLES,STAGE_GAP,QUIESCE_TIMEOUT)+1)` bits. The stage index is `$clog2(NUM_DOMAINS)` bits, minimum 1.

## Timing
- **Reset values** while `rst_n`=0, applied asynchronously: `rst_out_n`=0, `rst_done`=0, `sw_rst_ack`=0, `quiesce_req`=0, `timeout_flag`=0. State is `HOLD`.
- **Power-up:** cycle 0 is the first edge with `srst_n`=1 (2 edges after `rst_n` rises).
  - `rst_out_n[i]` rises at cycle `HOLD_CYCLES + i*STAGE_GAP`.
  - `rst_done` rises one cycle after `rst_out_n[NUM_DOMAINS-1]`.
- **Software reset:**
  - Request accepted at edge t: `quiesce_req` is high from t+1.
  - `quiesce_ack` sampled at edge u: at u+1, `quiesce_req`=0, all `rst_out_n`=0, `rst_done`=0. Release timing then follows the power-up formula with cycle 0 = u+1.
  - Timeout: the forced reset occurs at t+1+`QUIESCE_TIMEOUT`.
  - If `quiesce_ack` and the timeout arrive in the same cycle, ack wins and `timeout_flag` is not set.
- **Reset mid-operation:** `rst_n` low in any state asserts all outputs immediately and abandons any pending handshake. `sw_rst_ack` is not given for an abandoned request; a request still held restarts from `RUN`.

## Structure
- **`rst_seq_pkg`:** state enum, default parameter constants, and a `max3` function for counter sizing.
- **`rst_sync_cell`:** the 2-flop asynchronous-assert/synchronous-release synchronizer, one instance inside `rst_seq`. It is the only sub-module.

## Test plan
- **Power-up, defaults:** `rst_n` rises → `rst_out_n` bits rise at cycles 16, 20, 24, 28; `rst_done` at 29; `sw_rst_ack`=0.
- **Software reset, ack after 5 cycles:** req at t → `quiesce_req` t+1..t+5; outputs low t+6; `rst_out_n[0]` at t+22; `rst_done` and `sw_rst_ack` at t+35; `timeout_flag`=0.
- **Quiesce timeout:** `quiesce_ack` tied 0 → forced reset at t+65; `timeout_flag`=1 until the next accepted request.
- **`rst_n` mid-`RELEASE`:** pulse `rst_n` low at cycle 22 → all outputs 0 immediately; full power-up timing restarts.
- **Held request:** `sw_rst_req` held high across completion → exactly one sequence; ack drops the cycle after req is sampled low. A request raised during `HOLD` starts quiesce on `RUN` entry.
- **`NUM_DOMAINS`=1, `STAGE_GAP`=1, `HOLD_CYCLES`=1:** `rst_out_n[0]` at cycle 1, `rst_done` at 2.
